regfile_wr_ctrl: RTL and testbench

//  Owns the single write port (WA/WE/WD) of register_file. After reset it sweeps

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_wr_ctrl.sv | 117 +++++++++++
 tb/tb_regfile_wr_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above i_ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int unsigned w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_req[w_j[IDX_W-1:0]]) begin
        o_valid                = 1'b1;
        o_gnt[w_j[IDX_W-1:0]] = 1'b1;
        o_idx                  = w_j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Owns the register-file write port: zero sweep after reset/clear, then
// round-robin arbitration between writeback requesters with valid/ready.
module regfile_wr_ctrl #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            clear_req,
  output logic                            WE,
  output logic [ADDR_W-1:0]               WA,
  output logic [DATA_W-1:0]               WD,
  output logic                            init_done
);

  import regfile_pkg::*;

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rf_ctrl_state_t      r_state;
  logic [ADDR_W-1:0]   r_ctr;
  logic [IdxW-1:0]     r_rr_ptr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wa;
  logic [DATA_W-1:0]   r_wd;
  logic                r_init_done;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IdxW-1:0]     w_idx;
  logic                w_any;
  logic                w_grant_ok;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic [IdxW-1:0]     w_ptr_next;
  logic                w_sweep_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  // Ready depends only on valids, pointer and state, never on another ready.
  assign w_grant_ok = (r_state == RUN) && !clear_req;
  assign req_ready  = w_grant_ok ? w_gnt : '0;
  assign w_hs       = w_grant_ok && w_any;

  assign w_sel_addr   = req_addr[w_idx];
  assign w_sel_data   = req_data[w_idx];
  assign w_ptr_next   = (w_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_sweep_last = (r_ctr == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= CLEAR;
      r_ctr       <= '0;
      r_rr_ptr    <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_we  <= 1'b1;
          r_wa  <= r_ctr;
          r_wd  <= '0;
          r_ctr <= r_ctr + 1'b1;
          if (w_sweep_last) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
            r_ctr       <= '0;
          end
        end
        RUN: begin
          if (clear_req) begin
            r_state     <= CLEAR;
            r_ctr       <= '0;
            r_init_done <= 1'b0;
            r_we        <= 1'b0;
          end else if (w_hs) begin
            // x0 is hardwired: accept the transfer but suppress the write.
            r_we     <= (w_sel_addr != '0);
            r_wa     <= w_sel_addr;
            r_wd     <= w_sel_data;
            r_rr_ptr <= w_ptr_next;
          end else begin
            r_we <= 1'b0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign WE        = r_we;
  assign WA        = r_wa;
  assign WD        = r_wd;
  assign init_done = r_init_done;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!n_rst) $onehot0(req_ready));
  a_no_ready_clear: assert property (@(posedge clk) disable iff (!n_rst)
                                     (r_state == CLEAR) |-> (req_ready == '0));

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl with a behavioural register file behind the write port.
module tb_regfile_wr_ctrl;

  logic              clk;
  logic              n_rst;
  logic [1:0]        req_valid;
  logic [1:0][4:0]   req_addr;
  logic [1:0][31:0]  req_data;
  logic [1:0]        req_ready;
  logic              clear_req;
  logic              WE;
  logic [4:0]        WA;
  logic [31:0]       WD;
  logic              init_done;

  logic [31:0] mem [32];

  int checks   = 0;
  int failures = 0;

  regfile_wr_ctrl #(
    .NUM_REQ  (2),
    .ADDR_W   (5),
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clear_req (clear_req),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) if (WE) mem[WA] <= WD;

  task automatic test_reset();
    n_rst = 1'b0; clear_req = 1'b0; req_valid = 2'b11;
    req_addr[0] = 5'd3; req_addr[1] = 5'd4;
    req_data[0] = 32'd11; req_data[1] = 32'd22;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", WE); end
    checks++; if (WA !== 5'd0) begin failures++; $display("FAIL reset_wa got=%0d exp=0", WA); end
    checks++; if (WD !== 32'd0) begin failures++; $display("FAIL reset_wd got=%0h exp=0", WD); end
    checks++; if (init_done !== 1'b0) begin
      failures++; $display("FAIL reset_init_done got=%0b exp=0", init_done);
    end
    checks++; if (req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    @(negedge clk) n_rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      checks++; if (WE !== 1'b1 || WA !== 5'(i) || WD !== 32'd0) begin
        failures++; $display("FAIL sweep_write i=%0d got we=%0b wa=%0d wd=%0h exp we=1 wa=%0d wd=0",
                             i, WE, WA, WD, i);
      end
      checks++; if (init_done !== (i == 31)) begin
        failures++; $display("FAIL sweep_init_done i=%0d got=%0b exp=%0b", i, init_done, i == 31);
      end
      if (i < 31) begin
        checks++; if (req_ready !== 2'b00) begin
          failures++; $display("FAIL sweep_ready i=%0d got=%b exp=00", i, req_ready);
        end
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req_valid = 2'b01; req_addr[0] = 5'd5; req_data[0] = 32'd1001;
    #1;
    checks++; if (req_ready !== 2'b01) begin
      failures++; $display("FAIL single_ready0 got=%b exp=01", req_ready);
    end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || WA !== 5'd5 || WD !== 32'd1001) begin
      failures++; $display("FAIL single_out0 got we=%0b wa=%0d wd=%0d exp we=1 wa=5 wd=1001",
                           WE, WA, WD);
    end
    @(negedge clk);
    req_valid = 2'b10; req_addr[1] = 5'd6; req_data[1] = 32'd1002;
    #1;
    checks++; if (req_ready !== 2'b10) begin
      failures++; $display("FAIL single_ready1 got=%b exp=10", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (WE !== 1'b1 || WA !== 5'd6 || WD !== 32'd1002) begin
      failures++; $display("FAIL single_out1 got we=%0b wa=%0d wd=%0d exp we=1 wa=6 wd=1002",
                           WE, WA, WD);
    end
    checks++; if (mem[5] !== 32'd1001) begin
      failures++; $display("FAIL single_rd5 got=%0d exp=1001", mem[5]);
    end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL single_idle_we got=%0b exp=0", WE); end
    checks++; if (mem[6] !== 32'd1002) begin
      failures++; $display("FAIL single_rd6 got=%0d exp=1002", mem[6]);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] a0 [4];
    logic [4:0] a1 [4];
    int k0;
    int k1;
    int g;
    logic [4:0] exp_a;
    a0 = '{5'd1, 5'd2, 5'd3, 5'd4};
    a1 = '{5'd17, 5'd18, 5'd19, 5'd20};
    k0 = 0; k1 = 0;
    for (int step = 0; step < 8; step++) begin
      @(negedge clk);
      req_valid   = {k1 < 4, k0 < 4};
      req_addr[0] = (k0 < 4) ? a0[k0] : 5'd0;
      req_addr[1] = (k1 < 4) ? a1[k1] : 5'd0;
      req_data[0] = 32'd1000 + 32'(req_addr[0]);
      req_data[1] = 32'd1000 + 32'(req_addr[1]);
      g     = step % 2;
      exp_a = (g == 1) ? a1[k1] : a0[k0];
      #1;
      checks++; if (req_ready !== 2'(1 << g)) begin
        failures++; $display("FAIL rr_ready step=%0d got=%b exp=%b", step, req_ready, 2'(1 << g));
      end
      @(posedge clk); #1;
      checks++; if (WE !== 1'b1 || WA !== exp_a || WD !== 32'd1000 + 32'(exp_a)) begin
        failures++; $display("FAIL rr_write step=%0d got we=%0b wa=%0d wd=%0d exp we=1 wa=%0d wd=%0d",
                             step, WE, WA, WD, exp_a, 32'd1000 + 32'(exp_a));
      end
      if (g == 1) k1++; else k0++;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (mem[1] !== 32'd1001 || mem[4] !== 32'd1004 || mem[20] !== 32'd1020) begin
      failures++; $display("FAIL rr_readback got r1=%0d r4=%0d r20=%0d exp 1001 1004 1020",
                           mem[1], mem[4], mem[20]);
    end
  endtask

  task automatic test_addr_zero();
    @(negedge clk);
    req_valid = 2'b10; req_addr[1] = 5'd0; req_data[1] = 32'hDEAD;
    #1;
    checks++; if (req_ready !== 2'b10) begin
      failures++; $display("FAIL x0_ready got=%b exp=10", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL x0_we got=%0b exp=0", WE); end
    @(posedge clk); #1;
    checks++; if (mem[0] !== 32'd0) begin
      failures++; $display("FAIL x0_read got=%0h exp=0", mem[0]);
    end
  endtask

  task automatic test_clear();
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      req_valid = 2'b01; req_addr[0] = 5'(k); req_data[0] = 32'd1000 + 32'(k);
      @(posedge clk);
    end
    @(negedge clk) req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if (mem[1] !== 32'd1001 || mem[17] !== 32'd1017 || mem[31] !== 32'd1031) begin
      failures++; $display("FAIL fill_readback got r1=%0d r17=%0d r31=%0d exp 1001 1017 1031",
                           mem[1], mem[17], mem[31]);
    end
    @(negedge clk);
    req_valid = 2'b11; req_addr[0] = 5'd7; req_addr[1] = 5'd8; clear_req = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin
      failures++; $display("FAIL clear_ready got=%b exp=00", req_ready);
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    checks++; if (WE !== 1'b0 || init_done !== 1'b0) begin
      failures++; $display("FAIL clear_edge got we=%0b init_done=%0b exp 0 0", WE, init_done);
    end
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      checks++; if (WE !== 1'b1 || WA !== 5'(i) || WD !== 32'd0) begin
        failures++; $display("FAIL clear_sweep i=%0d got we=%0b wa=%0d wd=%0h exp we=1 wa=%0d wd=0",
                             i, WE, WA, WD, i);
      end
      if (i < 31) begin
        checks++; if (req_ready !== 2'b00 || init_done !== 1'b0) begin
          failures++; $display("FAIL clear_sweep_hs i=%0d got ready=%b init_done=%0b exp 00 0",
                               i, req_ready, init_done);
        end
      end
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      checks++; if (mem[r] !== 32'd0) begin
        failures++; $display("FAIL clear_read r=%0d got=%0d exp=0", r, mem[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 2'b01; req_addr[0] = 5'd9; req_data[0] = 32'd77;
    #1;
    checks++; if (req_ready !== 2'b01) begin
      failures++; $display("FAIL mid_ready got=%b exp=01", req_ready);
    end
    @(posedge clk); #1;
    checks++; if (WE !== 1'b1 || WA !== 5'd9) begin
      failures++; $display("FAIL mid_accept got we=%0b wa=%0d exp we=1 wa=9", WE, WA);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (WE !== 1'b0 || init_done !== 1'b0 || WA !== 5'd0 || WD !== 32'd0) begin
      failures++; $display("FAIL mid_async got we=%0b init_done=%0b wa=%0d wd=%0d exp 0 0 0 0",
                           WE, init_done, WA, WD);
    end
    checks++; if (req_ready !== 2'b00) begin
      failures++; $display("FAIL mid_ready_rst got=%b exp=00", req_ready);
    end
    @(posedge clk); #1;
    checks++; if (mem[9] !== 32'd0) begin
      failures++; $display("FAIL mid_dropped got=%0d exp=0", mem[9]);
    end
    @(negedge clk);
    n_rst = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      checks++; if (WE !== 1'b1 || WA !== 5'(i)) begin
        failures++; $display("FAIL mid_sweep i=%0d got we=%0b wa=%0d exp we=1 wa=%0d", i, WE, WA, i);
      end
    end
    checks++; if (req_ready !== 2'b01 || init_done !== 1'b1) begin
      failures++; $display("FAIL mid_rr_restart got ready=%b init_done=%0b exp 01 1",
                           req_ready, init_done);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_addr_zero();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
